pair_burst_packer: RTL and testbench
====================================

// Module: pair_burst_packer
// PURPOSE
// Downstream stage of the 1-to-2 funnel: captures each even/odd sample pair (dout0/dout1 of the
// funnel) into a pair FIFO and re-emits the data as fixed-length TDM bursts of packed pairs
// under a valid/ready handshake. Decouples the 200 MHz sample stream from a bursty consumer.
// PARAMETERS
// WIDTH      16  bits per sample lane
// DEPTH      16  FIFO depth in pairs; power of 2, >= 2
// BURST_LEN  4   pairs per output burst; 1 <= BURST_LEN <= DEPTH
// PORTS
// clk        in   1                 200 MHz clock, single domain
// rst        in   1                 synchronous reset, active-high
// din0       in   WIDTH             lane 0 sample (even), from funnel dout0
// din1       in   WIDTH             lane 1 sample (odd), from funnel dout1
// din_valid  in   1                 din0/din1 hold a new complete pair this cycle
// out_data   out  2*WIDTH           packed pair {lane1, lane0}
// out_valid  out  1                 out_data valid
// out_ready  in   1                 consumer accepts out_data when out_valid && out_ready
// out_sop    out  1                 first pair of burst (qualified by out_valid)
// out_eop    out  1                 last pair of burst (qualified by out_valid)
// fill       out  $clog2(DEPTH)+1   pairs currently stored
// overflow   out  1                 sticky: a pair was dropped because FIFO full
// burst_cnt  out  16                completed bursts, wraps 0xFFFF -> 0
// BEHAVIOUR
// - Reset (rst high at clk edge): ptrs=0, fill=0, state=IDLE, beat=0, overflow=0,
//   burst_cnt=0; out_valid/out_sop/out_eop = 0 from the next cycle. Reset mid-burst aborts the
//   burst: no eop issued, stored pairs discarded, burst_cnt not incremented.
// - Write: din_valid && fill<DEPTH -> store {din1,din0} at wr_ptr, wr_ptr++ (wraps mod DEPTH).
//   din_valid && fill==DEPTH -> pair dropped, overflow<=1; dropped even if a read pops same cycle.
// - Read: pop occurs iff out_valid && out_ready; rd_ptr++ (wraps mod DEPTH).
// - fill next = fill + write - pop; simultaneous write+pop leaves fill unchanged.
// - out_data = mem[rd_ptr] (combinational read of registered ptr); stable while stalled.
// - FSM, registered state and beat counter (0..BURST_LEN-1):
//   IDLE : out_valid=0. If fill >= BURST_LEN -> BURST, beat=0.
//   BURST: out_valid=1; out_sop=(beat==0); out_eop=(beat==BURST_LEN-1).
//          Pop with beat<BURST_LEN-1 -> beat++.
//          Pop with beat==BURST_LEN-1 -> burst_cnt++, beat=0; next state BURST if
//          (fill - 1 + write) >= BURST_LEN else IDLE (back-to-back bursts, no idle gap).
//          No pop -> hold all outputs (out_ready low stalls mid-burst freely).
// - A burst only starts with >= BURST_LEN pairs stored, so the FIFO never underflows in BURST.
// - BURST_LEN==1: every beat has out_sop=out_eop=1.
// - Latency: pair written at edge N with fill then BURST_LEN-1 -> fill==BURST_LEN after edge
//   N, FSM enters BURST at edge N+1, out_valid high in the cycle after edge N+1.
// - overflow clears only on rst. fill never exceeds DEPTH.
// TESTING
// 1 Reset, then 4 pairs (0x0001/0x0002..0x0007/0x0008) on consecutive cycles, out_ready=1 ->
//   one burst: 0x00020001(sop),0x00040003,0x00060005,0x00080007(eop); burst_cnt=1; fill=0.
// 2 3 pairs only -> out_valid stays 0, fill=3; 4th pair -> out_valid 2 cycles after its write.
// 3 16 pairs, out_ready=0, then 17th pair -> overflow=1, fill=16; release ready -> 4 bursts
//   of 4 in order, sop/eop on beats 0/3, no gaps, burst_cnt=4, 17th pair never output.
// 4 Stream pairs every other cycle (funnel rate) with out_ready toggling 1,0 -> out_data
//   stable during stalls, order preserved, no drop; ptr wrap after 16 pairs checked.
// 5 Pulse rst while beat==2 of a burst -> next cycle out_valid=0, fill=0, burst_cnt unchanged,
//   overflow=0; new 4 pairs then produce a clean sop..eop burst.
// 6 fill==DEPTH with simultaneous pop and din_valid -> pair dropped, overflow=1, fill=15.

Source files
------------

// File: rtl/pair_burst_packer.sv
// Pair FIFO that captures even/odd sample pairs and replays them as fixed-length
// bursts of packed {lane1, lane0} words under a valid/ready handshake.
module pair_burst_packer #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           din0,
  input  logic [WIDTH-1:0]           din1,
  input  logic                       din_valid,
  output logic [2*WIDTH-1:0]         out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       overflow,
  output logic [15:0]                burst_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = PW + 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [FW-1:0] DEPTH_F   = FW'(DEPTH);
  localparam logic [FW-1:0] BURST_F   = FW'(BURST_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  logic [2*WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  state_t        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   burst_cnt_q, burst_cnt_d;

  logic write;
  logic pop;

  assign out_valid = (state_q == BURST);
  assign out_sop   = out_valid && (beat_q == '0);
  assign out_eop   = out_valid && (beat_q == LAST_BEAT);
  assign out_data  = mem_q[rd_ptr_q];
  assign fill      = fill_q;
  assign overflow  = overflow_q;
  assign burst_cnt = burst_cnt_q;

  always_comb begin
    write       = din_valid && (fill_q != DEPTH_F);
    pop         = out_valid && out_ready;
    wr_ptr_d    = write ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    fill_d      = fill_q + FW'(write) - FW'(pop);
    // A full FIFO drops the incoming pair even if a pop frees a slot this cycle.
    overflow_d  = overflow_q | (din_valid && (fill_q == DEPTH_F));
    state_d     = state_q;
    beat_d      = beat_q;
    burst_cnt_d = burst_cnt_q;

    case (state_q)
      IDLE: begin
        if (fill_q >= BURST_F) begin
          state_d = BURST;
          beat_d  = '0;
        end
      end
      BURST: begin
        if (pop) begin
          if (beat_q == LAST_BEAT) begin
            burst_cnt_d = burst_cnt_q + 16'd1;
            beat_d      = '0;
            state_d     = (fill_d >= BURST_F) ? BURST : IDLE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      state_q     <= IDLE;
      beat_q      <= '0;
      overflow_q  <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      state_q     <= state_d;
      beat_q      <= beat_d;
      overflow_q  <= overflow_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (write) begin
      mem_q[wr_ptr_q] <= {din1, din0};
    end
  end

endmodule

// File: tb/tb_pair_burst_packer.sv
// Directed and randomized bench for pair_burst_packer, checked every cycle against
// a queue-based reference model of the pair FIFO and burst framing.
`timescale 1ns/1ps
module tb_pair_burst_packer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int BL    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [WIDTH-1:0]  din0 = '0;
  logic [WIDTH-1:0]  din1 = '0;
  logic              din_valid = 1'b0;
  logic [2*WIDTH-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_sop;
  logic              out_eop;
  logic [$clog2(DEPTH):0] fill;
  logic              overflow;
  logic [15:0]       burst_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mq[$];
  bit          m_burst;
  int          m_beat;
  logic [15:0] m_cnt;
  bit          m_ovf;

  pair_burst_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .din0(din0), .din1(din1), .din_valid(din_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .fill(fill), .overflow(overflow),
    .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit dv, input logic [15:0] d0, input logic [15:0] d1,
                            input bit rdy, input bit rs);
    int  pre;
    bit  pop;
    bit  wr;
    logic [31:0] dummy;
    if (rs) begin
      mq.delete();
      m_burst = 0;
      m_beat  = 0;
      m_ovf   = 0;
      m_cnt   = '0;
    end else begin
      pre = mq.size();
      pop = m_burst && rdy;
      wr  = dv && (pre < DEPTH);
      if (dv && pre >= DEPTH) m_ovf = 1;
      if (pop) dummy = mq.pop_front();
      if (wr) mq.push_back({d1, d0});
      if (!m_burst) begin
        if (pre >= BL) begin
          m_burst = 1;
          m_beat  = 0;
        end
      end else if (pop) begin
        if (m_beat == BL - 1) begin
          m_cnt   = m_cnt + 16'd1;
          m_beat  = 0;
          m_burst = (mq.size() >= BL);
        end else begin
          m_beat++;
        end
      end
    end
  endtask

  task automatic step(input bit dv, input logic [15:0] d0, input logic [15:0] d1,
                      input bit rdy, input bit rs);
    din_valid = dv;
    din0      = d0;
    din1      = d1;
    out_ready = rdy;
    rst       = rs;
    @(posedge clk);
    model_edge(dv, d0, d1, rdy, rs);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_burst));
    chk("out_sop", 32'(out_sop), 32'(m_burst && m_beat == 0));
    chk("out_eop", 32'(out_eop), 32'(m_burst && m_beat == BL - 1));
    chk("fill", 32'(fill), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("burst_cnt", 32'(burst_cnt), 32'(m_cnt));
    if (m_burst) chk("out_data", out_data, mq[0]);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 16'h0, 16'h0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] exp_word;

    // Reset state
    do_reset();
    chk("reset_fill", 32'(fill), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);

    // Test 1: one burst of four known pairs
    for (int i = 0; i < 4; i++) step(1'b1, 16'(2*i+1), 16'(2*i+2), 1'b1, 1'b0);
    idle(1'b1);
    for (int i = 0; i < 4; i++) begin
      exp_word = {16'(2*i+2), 16'(2*i+1)};
      chk("t1_data", out_data, exp_word);
      chk("t1_sop", 32'(out_sop), 32'(i == 0));
      chk("t1_eop", 32'(out_eop), 32'(i == 3));
      idle(1'b1);
    end
    chk("t1_burst_cnt", 32'(burst_cnt), 32'd1);
    chk("t1_fill", 32'(fill), 32'd0);
    chk("t1_valid_after", 32'(out_valid), 32'd0);

    // Test 2: three pairs do not start a burst; fourth starts one a cycle later
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 16'h100 + 16'(i), 16'h200 + 16'(i), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("t2_valid_low", 32'(out_valid), 32'd0);
    chk("t2_fill3", 32'(fill), 32'd3);
    step(1'b1, 16'h103, 16'h203, 1'b1, 1'b0);
    chk("t2_valid_edgeN", 32'(out_valid), 32'd0);
    idle(1'b1);
    chk("t2_valid_edgeN1", 32'(out_valid), 32'd1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Test 3: fill completely, overflow on 17th, then drain four back-to-back bursts
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 16'(2*i+1), 16'(2*i+2), 1'b0, 1'b0);
    chk("t3_fill16", 32'(fill), 32'd16);
    chk("t3_no_ovf", 32'(overflow), 32'd0);
    step(1'b1, 16'hBEEF, 16'hDEAD, 1'b0, 1'b0);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_fill_full", 32'(fill), 32'd16);
    for (int i = 0; i < 16; i++) begin
      exp_word = {16'(2*i+2), 16'(2*i+1)};
      chk("t3_valid", 32'(out_valid), 32'd1);
      chk("t3_data", out_data, exp_word);
      chk("t3_sop", 32'(out_sop), 32'((i % 4) == 0));
      chk("t3_eop", 32'(out_eop), 32'((i % 4) == 3));
      idle(1'b1);
    end
    chk("t3_burst_cnt", 32'(burst_cnt), 32'd4);
    chk("t3_fill_empty", 32'(fill), 32'd0);
    chk("t3_valid_end", 32'(out_valid), 32'd0);

    // Test 4: funnel-rate stream with ready toggling; pointers wrap past 16 pairs
    do_reset();
    for (int k = 0; k < 80; k++) begin
      step((k % 2) == 0, 16'($urandom), 16'($urandom), (k % 2) == 0, 1'b0);
    end
    for (int k = 0; k < 20; k++) idle(1'b1);
    chk("t4_no_ovf", 32'(overflow), 32'd0);
    chk("t4_burst_cnt", 32'(burst_cnt), 32'd10);

    // Test 5: reset in the middle of a burst (beat 2)
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 16'h500 + 16'(i), 16'h600 + 16'(i), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("t5_mid_valid", 32'(out_valid), 32'd1);
    chk("t5_mid_sop", 32'(out_sop), 32'd0);
    chk("t5_mid_eop", 32'(out_eop), 32'd0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_fill", 32'(fill), 32'd0);
    chk("t5_cnt", 32'(burst_cnt), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h700 + 16'(i), 16'h800 + 16'(i), 1'b1, 1'b0);
    idle(1'b1);
    chk("t5_new_sop", 32'(out_sop), 32'd1);
    chk("t5_new_data", out_data, 32'h08000700);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("t5_new_cnt", 32'(burst_cnt), 32'd1);

    // Test 6: full FIFO with simultaneous pop and write still drops the pair
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 16'(i + 100), 1'b0, 1'b0);
    step(1'b1, 16'hAAAA, 16'hBBBB, 1'b1, 1'b0);
    chk("t6_fill15", 32'(fill), 32'd15);
    chk("t6_ovf", 32'(overflow), 32'd1);

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 9) < 6), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 199) == 0));
    end
    for (int k = 0; k < 40; k++) idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
